// File: rtl/square_wave_pkg.sv
// Shared constants and helpers for the square-wave qualifier.
// Defaults give a 1 ms half-period (500 Hz) at a 30 MHz clock.
package square_wave_pkg;

    localparam int HALF_PERIOD_CYC = 30000;
    localparam int TOL_CYC         = 3000;
    localparam int MATCH_COUNT     = 4;
    localparam int CNT_W           = 17;

    localparam int WIN_LO = HALF_PERIOD_CYC - TOL_CYC;
    localparam int WIN_HI = HALF_PERIOD_CYC + TOL_CYC;

    function automatic logic in_window(int len, int lo, int hi);
        return (len >= lo) && (len <= hi);
    endfunction

endpackage

// File: rtl/sq_edge_sync.sv
// Two-flop synchronizer plus a delay flop for edge detection.
// Emits a one-cycle pulse on every rising or falling input edge.
module sq_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // synchronize the pin and keep one delayed copy for the XOR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 ^ s3;

endmodule

// File: rtl/square_wave_detector.sv
// Measures every half-period of an asynchronous square wave and
// drives oState_n low once enough consecutive halves are in window.
module square_wave_detector #(
    parameter int HALF_PERIOD_CYC = square_wave_pkg::HALF_PERIOD_CYC,
    parameter int TOL_CYC         = square_wave_pkg::TOL_CYC,
    parameter int MATCH_COUNT     = square_wave_pkg::MATCH_COUNT,
    parameter int CNT_W           = square_wave_pkg::CNT_W
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic isquareWave,
    output logic oState_n
);

    import square_wave_pkg::*;

    localparam int LO = HALF_PERIOD_CYC - TOL_CYC;
    localparam int HI = HALF_PERIOD_CYC + TOL_CYC;
    localparam int MW = $clog2(MATCH_COUNT + 1);

    localparam logic [CNT_W-1:0] SAT   = CNT_W'(HI + 1);
    localparam logic [MW-1:0]    MATCH = MW'(MATCH_COUNT);

    logic             edge_pulse;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [MW-1:0]    match;
    logic [MW-1:0]    match_nxt;
    logic             armed;
    logic             armed_nxt;
    logic             state_nxt;

    sq_edge_sync u_sync (
        .clk   (iClk),
        .rst_n (iRst_n),
        .din   (isquareWave),
        .pulse (edge_pulse)
    );

    // an edge always wins over saturation; a saturated count is too long
    always_comb begin
        cnt_nxt   = cnt;
        match_nxt = match;
        armed_nxt = armed;
        if (edge_pulse) begin
            cnt_nxt = CNT_W'(1);
            if (armed) begin
                if (in_window(int'(cnt), LO, HI)) begin
                    if (match != MATCH) begin
                        match_nxt = match + 1'b1;
                    end
                end else begin
                    match_nxt = '0;
                end
            end else begin
                armed_nxt = 1'b1;
            end
        end else if (cnt == SAT) begin
            match_nxt = '0;
            armed_nxt = 1'b0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        state_nxt = (match_nxt != MATCH);
    end

    // measurement state and the registered status output
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt      <= '0;
            match    <= '0;
            armed    <= 1'b0;
            oState_n <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            match    <= match_nxt;
            armed    <= armed_nxt;
            oState_n <= state_nxt;
        end
    end

endmodule

// File: tb/tb_square_wave_detector.sv
// Self-checking bench for square_wave_detector, scaled-down timing.
// Reference model works on edge timestamps, checked every cycle.
module tb_square_wave_detector;

    localparam int HALF  = 100;
    localparam int TOL   = 10;
    localparam int MATCH = 4;
    localparam int CNTW  = 8;
    localparam int LO    = HALF - TOL;
    localparam int HI    = HALF + TOL;
    localparam int SAT   = HI + 1;
    localparam int MAXC  = 99990;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic state_n;

    int    n_vec  = 0;
    int    n_bad  = 0;
    int    cyc    = 0;
    bit    lvl [0:99999];
    bit    armed  = 1'b0;
    int    last   = 0;
    int    streak = 0;
    logic  exp_n  = 1'b1;
    string tag    = "init";

    square_wave_detector #(
        .HALF_PERIOD_CYC (HALF),
        .TOL_CYC         (TOL),
        .MATCH_COUNT     (MATCH),
        .CNT_W           (CNTW)
    ) dut (
        .iClk        (clk),
        .iRst_n      (rst_n),
        .isquareWave (din),
        .oState_n    (state_n)
    );

    always #5 clk = ~clk;

    task automatic check(string t, logic got, logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", t, cyc, got, want);
        end
    endtask

    // Edges reach the measurement logic three cycles after the pin moves.
    // Lock = last MATCH timed half-periods all within [LO,HI].
    task automatic model_step();
        int  p;
        int  len;
        bit  edg;
        p = cyc;
        if (!rst_n) begin
            streak = 0;
            armed  = 1'b0;
        end else begin
            edg = (p >= 4) && (lvl[p-3] != lvl[p-4]);
            if (edg) begin
                if (armed) begin
                    len = p - last;
                    if (len >= LO && len <= HI)
                        streak = (streak < MATCH) ? streak + 1 : MATCH;
                    else
                        streak = 0;
                end else begin
                    armed = 1'b1;
                end
                last = p;
            end else if (armed && (p - last) >= SAT) begin
                streak = 0;
                armed  = 1'b0;
            end
        end
        exp_n = (streak != MATCH);
    endtask

    task automatic step();
        if (cyc >= MAXC) begin
            $display("FAIL budget cyc=%0d got=over want=under", cyc);
            $display("== %0d vectors applied, %0d miscompares ==",
                     n_vec, n_bad + 1);
            $fatal(1, "cycle budget exceeded");
        end
        lvl[cyc] = din;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check(tag, state_n, exp_n);
    endtask

    task automatic half(int n);
        repeat (n) step();
        din = ~din;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            din = ~din;
            step();
        end
        din = 1'b0;
        repeat (4) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int n;

        tag = "reset";
        do_reset();

        tag = "arm";
        half(200);
        tag = "lock";
        repeat (7) half(HALF);

        tag = "short";
        repeat (6) half(20);
        tag = "relock";
        repeat (7) half(HALF);

        tag = "timeout";
        repeat (4) half(2 * HALF);
        tag = "relock_to";
        repeat (6) half(HALF);

        tag = "win_lo_in";
        half(LO);
        tag = "win_hi_in";
        half(HI);
        half(HALF);
        tag = "win_lo_out";
        half(LO - 1);
        tag = "relock_lo";
        repeat (5) half(HALF);
        tag = "win_hi_out";
        half(HI + 1);
        tag = "relock_hi";
        repeat (5) half(HALF);
        tag = "past_sat";
        half(SAT + 1);
        tag = "relock_sat";
        repeat (6) half(HALF);

        tag = "mid_reset";
        do_reset();
        tag = "after_reset";
        repeat (6) half(HALF);

        tag = "random";
        repeat (250) begin
            r = $urandom_range(0, 9);
            if (r < 7)
                n = $urandom_range(LO - 5, HI + 5);
            else
                n = $urandom_range(1, 250);
            half(n);
        end

        tag = "tail";
        repeat (300) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
